// File: rtl/mult_div_unit_if.sv
// Pipeline <-> multiply/divide unit bundle: op request, operands,
// start/busy status and the architected HI/LO values.
interface mult_div_unit_if;
    logic [2:0]  mdu_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        start;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output mdu_op, A, B,
        input  start, busy, HI, LO
    );

    modport slave (
        input  mdu_op, A, B,
        output start, busy, HI, LO
    );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with private HI/LO registers.
// Optional MDU_DIV0_HOLD_EN: divide by zero is refused and HI/LO hold.
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input logic            clk,
    input logic            reset,
    mult_div_unit_if.slave bus
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] MULT_N = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_N  = CW'(DIV_CYCLES);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          busy_q;
    logic [31:0]   hi_q, lo_q;
    logic [31:0]   hi_n, lo_n;

    logic is_mult, is_multu, is_div, is_divu, is_dv;
    logic is_mthi, is_mtlo, b_zero, div0_block, start_c;

    assign is_mult  = (bus.mdu_op == OP_MULT);
    assign is_multu = (bus.mdu_op == OP_MULTU);
    assign is_div   = (bus.mdu_op == OP_DIV);
    assign is_divu  = (bus.mdu_op == OP_DIVU);
    assign is_mthi  = (bus.mdu_op == OP_MTHI);
    assign is_mtlo  = (bus.mdu_op == OP_MTLO);
    assign is_dv    = is_div | is_divu;
    assign b_zero   = (bus.B == 32'd0);

`ifdef MDU_DIV0_HOLD_EN
    assign div0_block = is_dv & b_zero;
`else
    assign div0_block = 1'b0;
`endif

    assign start_c = (is_mult | is_multu | is_dv) & ~busy_q & ~reset & ~div0_block;

    logic [63:0] prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag;
    logic        neg_q, neg_r;
    logic [31:0] res_hi, res_lo;

    // Signed divide works on magnitudes, so 0x80000000 / -1 needs no special case
    always_comb begin
        prod   = 64'd0;
        a_mag  = bus.A;
        b_mag  = bus.B;
        q_mag  = 32'd0;
        r_mag  = 32'd0;
        neg_q  = 1'b0;
        neg_r  = 1'b0;
        res_hi = 32'd0;
        res_lo = 32'd0;
        if (is_div) begin
            a_mag = bus.A[31] ? (~bus.A + 32'd1) : bus.A;
            b_mag = bus.B[31] ? (~bus.B + 32'd1) : bus.B;
            neg_q = bus.A[31] ^ bus.B[31];
            neg_r = bus.A[31];
        end
        if (!b_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        unique case (1'b1)
            is_mult: begin
                prod = {{32{bus.A[31]}}, bus.A} * {{32{bus.B[31]}}, bus.B};
                {res_hi, res_lo} = prod;
            end
            is_multu: begin
                prod = {32'd0, bus.A} * {32'd0, bus.B};
                {res_hi, res_lo} = prod;
            end
            is_dv && b_zero: begin
                res_lo = 32'hFFFF_FFFF;
                res_hi = bus.A;
            end
            is_dv && !b_zero: begin
                res_lo = neg_q ? (~q_mag + 32'd1) : q_mag;
                res_hi = neg_r ? (~r_mag + 32'd1) : r_mag;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            busy_q <= 1'b0;
            hi_q   <= 32'd0;
            lo_q   <= 32'd0;
            hi_n   <= 32'd0;
            lo_n   <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_c) begin
                        hi_n   <= res_hi;
                        lo_n   <= res_lo;
                        cnt    <= is_dv ? DIV_N : MULT_N;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end else if (is_mthi) begin
                        hi_q <= bus.A;
                    end else if (is_mtlo) begin
                        lo_q <= bus.A;
                    end
                end
                RUN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi_q   <= hi_n;
                        lo_q   <= lo_n;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.start = start_c;
    assign bus.busy  = busy_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: default latencies plus a
// MULT_CYCLES=1 instance for back-to-back issue.
module tb_mult_div_unit;

    localparam logic [2:0] NONE  = 3'd0;
    localparam logic [2:0] MULT  = 3'd1;
    localparam logic [2:0] MULTU = 3'd2;
    localparam logic [2:0] DIV   = 3'd3;
    localparam logic [2:0] DIVU  = 3'd4;
    localparam logic [2:0] MTHI  = 3'd5;
    localparam logic [2:0] MTLO  = 3'd6;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    mult_div_unit_if bus ();
    mult_div_unit_if bus2 ();

    mult_div_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    mult_div_unit #(.MULT_CYCLES(1)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    always #5 clk = ~clk;

    // Issue one op for one cycle, then count busy cycles (bounded).
    task automatic run_op(input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int cyc,
                          output logic st);
        @(negedge clk);
        bus.mdu_op = op;
        bus.A      = a;
        bus.B      = b;
        #1;
        st = bus.start;
        @(negedge clk);
        bus.mdu_op = NONE;
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        bus.mdu_op = MULT;
        bus.A = 32'd3;
        bus.B = 32'd4;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (bus.start !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_start got %b want 0", bus.start);
        end
        vectors++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_state got busy=%b HI=%h LO=%h want 0/0/0",
                     bus.busy, bus.HI, bus.LO);
        end
        vectors++;
        if (bus2.busy !== 1'b0 || bus2.LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_dut2 got busy=%b LO=%h want 0/0", bus2.busy, bus2.LO);
        end
        bus.mdu_op = NONE;
        reset = 1'b0;
    endtask

    task automatic test_mult;
        int c;
        logic st;
        run_op(MULT, 32'hFFFF_FFFF, 32'd2, c, st);
        vectors++;
        if (st !== 1'b1) begin
            miscompares++;
            $display("FAIL mult_start got %b want 1", st);
        end
        vectors++;
        if (c != 5) begin
            miscompares++;
            $display("FAIL mult_busy_cycles got %0d want 5", c);
        end
        vectors++;
        if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL mult_result got %h_%h want ffffffff_fffffffe", bus.HI, bus.LO);
        end
        run_op(MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, c, st);
        vectors++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'd6) begin
            miscompares++;
            $display("FAIL mult_negneg got %h_%h want 00000000_00000006", bus.HI, bus.LO);
        end
        run_op(MULTU, 32'hFFFF_FFFF, 32'd2, c, st);
        vectors++;
        if (c != 5 || bus.HI !== 32'd1 || bus.LO !== 32'hFFFF_FFFE) begin
            miscompares++;
            $display("FAIL multu got cyc=%0d %h_%h want 5 00000001_fffffffe", c, bus.HI, bus.LO);
        end
    endtask

    task automatic test_div;
        int c;
        logic st;
        run_op(DIV, 32'hFFFF_FFF9, 32'd2, c, st);
        vectors++;
        if (c != 10) begin
            miscompares++;
            $display("FAIL div_busy_cycles got %0d want 10", c);
        end
        vectors++;
        if (bus.HI !== 32'hFFFF_FFFF || bus.LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", bus.HI, bus.LO);
        end
        run_op(DIV, 32'd7, 32'hFFFF_FFFE, c, st);
        vectors++;
        if (bus.HI !== 32'd1 || bus.LO !== 32'hFFFF_FFFD) begin
            miscompares++;
            $display("FAIL div_negdivisor got %h_%h want 00000001_fffffffd", bus.HI, bus.LO);
        end
        run_op(DIVU, 32'd7, 32'd2, c, st);
        vectors++;
        if (c != 10 || bus.HI !== 32'd1 || bus.LO !== 32'd3) begin
            miscompares++;
            $display("FAIL divu got cyc=%0d %h_%h want 10 00000001_00000003", c, bus.HI, bus.LO);
        end
        run_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, c, st);
        vectors++;
        if (bus.HI !== 32'd0 || bus.LO !== 32'h8000_0000) begin
            miscompares++;
            $display("FAIL div_overflow got %h_%h want 00000000_80000000", bus.HI, bus.LO);
        end
    endtask

    task automatic test_mt;
        @(negedge clk);
        bus.mdu_op = MTHI;
        bus.A = 32'h1234_5678;
        #1;
        vectors++;
        if (bus.start !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi_start got %b want 0", bus.start);
        end
        @(negedge clk);
        bus.mdu_op = MTLO;
        bus.A = 32'h0000_ABCD;
        vectors++;
        if (bus.HI !== 32'h1234_5678 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mthi got HI=%h busy=%b want 12345678/0", bus.HI, bus.busy);
        end
        @(negedge clk);
        bus.mdu_op = NONE;
        vectors++;
        if (bus.LO !== 32'h0000_ABCD || bus.HI !== 32'h1234_5678 || bus.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL mtlo got HI=%h LO=%h busy=%b want 12345678/0000abcd/0",
                     bus.HI, bus.LO, bus.busy);
        end
    endtask

    task automatic test_mt_ignored;
        int c;
        @(negedge clk);
        bus.mdu_op = MULT;
        bus.A = 32'd3;
        bus.B = 32'd5;
        @(negedge clk);
        bus.mdu_op = MTLO;
        bus.A = 32'h0000_DEAD;
        @(negedge clk);
        @(negedge clk);
        bus.mdu_op = NONE;
        c = 2;
        while (bus.busy === 1'b1 && c < 40) begin
            c++;
            @(negedge clk);
        end
        vectors++;
        if (c != 5 || bus.HI !== 32'd0 || bus.LO !== 32'd15) begin
            miscompares++;
            $display("FAIL mtlo_during_busy got cyc=%0d %h_%h want 5 00000000_0000000f",
                     c, bus.HI, bus.LO);
        end
    endtask

    task automatic test_div0;
        int c;
        logic st;
        @(negedge clk);
        bus.mdu_op = MTHI;
        bus.A = 32'h11;
        @(negedge clk);
        bus.mdu_op = MTLO;
        bus.A = 32'h22;
        run_op(DIV, 32'h55, 32'd0, c, st);
`ifdef MDU_DIV0_HOLD_EN
        vectors++;
        if (st !== 1'b0 || c != 0) begin
            miscompares++;
            $display("FAIL div0_hold got start=%b cyc=%0d want 0/0", st, c);
        end
        vectors++;
        if (bus.HI !== 32'h11 || bus.LO !== 32'h22) begin
            miscompares++;
            $display("FAIL div0_hold_hilo got %h_%h want 00000011_00000022", bus.HI, bus.LO);
        end
`else
        vectors++;
        if (st !== 1'b1 || c != 10) begin
            miscompares++;
            $display("FAIL div0_run got start=%b cyc=%0d want 1/10", st, c);
        end
        vectors++;
        if (bus.HI !== 32'h55 || bus.LO !== 32'hFFFF_FFFF) begin
            miscompares++;
            $display("FAIL div0_result got %h_%h want 00000055_ffffffff", bus.HI, bus.LO);
        end
`endif
    endtask

    task automatic test_reset_mid;
        int c;
        logic st;
        @(negedge clk);
        bus.mdu_op = DIV;
        bus.A = 32'd100;
        bus.B = 32'd7;
        @(negedge clk);
        bus.mdu_op = NONE;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (bus.busy !== 1'b0 || bus.HI !== 32'd0 || bus.LO !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_mid_run got busy=%b HI=%h LO=%h want 0/0/0",
                     bus.busy, bus.HI, bus.LO);
        end
        run_op(MULT, 32'd6, 32'd7, c, st);
        vectors++;
        if (st !== 1'b1 || c != 5 || bus.HI !== 32'd0 || bus.LO !== 32'd42) begin
            miscompares++;
            $display("FAIL mult_after_reset got start=%b cyc=%0d %h_%h want 1 5 0_2a",
                     st, c, bus.HI, bus.LO);
        end
    endtask

    task automatic test_back_to_back;
        logic        exp_st;
        logic [31:0] exp_lo;
        @(negedge clk);
        bus2.mdu_op = MULT;
        bus2.B = 32'd3;
        for (int i = 0; i < 8; i++) begin
            bus2.A = 32'(i + 1);
            #1;
            exp_st = (i % 2 == 0);
            vectors++;
            if (bus2.start !== exp_st || bus2.busy !== !exp_st) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d got start=%b busy=%b want %b/%b",
                         i, bus2.start, bus2.busy, exp_st, !exp_st);
            end
            if (i >= 2) begin
                exp_lo = 32'((i - (i % 2) - 1) * 3);
                vectors++;
                if (bus2.LO !== exp_lo || bus2.HI !== 32'd0) begin
                    miscompares++;
                    $display("FAIL b2b_result%0d got %h_%h want 00000000_%h",
                             i, bus2.HI, bus2.LO, exp_lo);
                end
            end
            @(negedge clk);
        end
        bus2.mdu_op = NONE;
    endtask

    initial begin
        clk = 1'b0;
        reset = 1'b1;
        vectors = 0;
        miscompares = 0;
        bus.mdu_op = NONE;
        bus.A = 32'd0;
        bus.B = 32'd0;
        bus2.mdu_op = NONE;
        bus2.A = 32'd0;
        bus2.B = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_mt();
        test_mt_ignored();
        test_div0();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
